// File: rtl/panel_pkg.sv
// Shared pixel_ram geometry, pixel bit layout and loader state encoding.
package panel_pkg;

    localparam int RAM_ADDR_W = 12;
    localparam int RAM_DATA_W = 16;

    // Pixel word layout: top R,G,B then bottom R,G,B, low bits reserved
    localparam int PIX_R_TOP    = 15;
    localparam int PIX_G_TOP    = 14;
    localparam int PIX_B_TOP    = 13;
    localparam int PIX_R_BOT    = 12;
    localparam int PIX_G_BOT    = 11;
    localparam int PIX_B_BOT    = 10;
    localparam int PIX_RSVD_HI  = 9;
    localparam int PIX_RSVD_LO  = 0;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ADDR = 2'd1;
    localparam logic [1:0] ST_DATA = 2'd2;

endpackage

// File: rtl/spi_frame_loader_if.sv
// pixel_ram write port as driven by the SPI frame loader.
interface spi_frame_loader_if
    import panel_pkg::*;
#(
    parameter int ADDR_W = RAM_ADDR_W,
    parameter int DATA_W = RAM_DATA_W
);
    logic [ADDR_W-1:0] o_ram_w_addr;
    logic [DATA_W-1:0] o_ram_w_data;
    logic              o_ram_w_enable;

    modport master (output o_ram_w_addr, output o_ram_w_data, output o_ram_w_enable);
    modport slave  (input  o_ram_w_addr, input  o_ram_w_data, input  o_ram_w_enable);
endinterface

// File: rtl/spi_input_sync.sv
// N-stage synchroniser for one async input, with delayed copy and edge pulses.
module spi_input_sync #(
    parameter int unsigned STAGES    = 2,
    parameter logic        RESET_VAL = 1'b0
) (
    input  logic clk_48mhz,
    input  logic reset,
    input  logic async_in,
    output logic sync_out,
    output logic sync_dly,
    output logic rise,
    output logic fall
);
    logic [STAGES-1:0] chain;

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            chain    <= {STAGES{RESET_VAL}};
            sync_dly <= RESET_VAL;
        end else begin
            chain    <= {chain[STAGES-2:0], async_in};
            sync_dly <= sync_out;
        end
    end

    assign sync_out = chain[STAGES-1];
    assign rise     = sync_out & ~sync_dly;
    assign fall     = ~sync_out & sync_dly;
endmodule

// File: rtl/spi_frame_loader.sv
// SPI-slave pixel loader: first word of a CS-low transaction is the start
// address, each following 16-bit word is written to pixel_ram at ascending addresses.
module spi_frame_loader
    import panel_pkg::*;
#(
    parameter int ADDR_W      = RAM_ADDR_W,
    parameter int DATA_W      = RAM_DATA_W,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk_48mhz,
    input  logic                 reset,
    input  logic                 i_spi_sck,
    input  logic                 i_spi_cs_n,
    input  logic                 i_spi_mosi,
    spi_frame_loader_if.master   ram_w,
    output logic                 o_frame_done,
    output logic                 o_busy,
    output logic [ADDR_W:0]      o_word_count
);
    localparam int BC_W = $clog2(DATA_W);
    localparam int WC_W = ADDR_W + 1;
    localparam logic [WC_W-1:0] WC_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic sck_s, sck_dly, sck_rise, sck_fall;
    logic cs_s, cs_dly, cs_rise, cs_fall;
    logic [SYNC_STAGES-1:0] mosi_chain;
    logic mosi_s;

    logic [1:0]        state;
    logic [BC_W-1:0]   bit_cnt;
    logic [DATA_W-1:0] shift;
    logic [DATA_W-1:0] word_next;
    logic              last_bit;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              wen;

    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sck_sync (
        .clk_48mhz (clk_48mhz), .reset (reset), .async_in (i_spi_sck),
        .sync_out  (sck_s), .sync_dly (sck_dly), .rise (sck_rise), .fall (sck_fall)
    );

    // CS_n idles high, so its chain resets high to avoid a false edge
    spi_input_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_cs_sync (
        .clk_48mhz (clk_48mhz), .reset (reset), .async_in (i_spi_cs_n),
        .sync_out  (cs_s), .sync_dly (cs_dly), .rise (cs_rise), .fall (cs_fall)
    );

    always_ff @(posedge clk_48mhz) begin
        if (reset) mosi_chain <= '0;
        else       mosi_chain <= {mosi_chain[SYNC_STAGES-2:0], i_spi_mosi};
    end
    assign mosi_s = mosi_chain[SYNC_STAGES-1];

    assign word_next = {shift[DATA_W-2:0], mosi_s};
    assign last_bit  = (bit_cnt == BC_W'(DATA_W-1));

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            shift        <= '0;
            addr         <= '0;
            wdata        <= '0;
            wen          <= 1'b0;
            o_frame_done <= 1'b0;
            o_word_count <= '0;
        end else begin
            o_frame_done <= 1'b0;
            // Post-strobe bookkeeping runs regardless of state so a CS rise
            // right after the last bit still completes the pending write.
            if (wen) begin
                wen  <= 1'b0;
                addr <= addr + ADDR_W'(1);
                if (o_word_count != WC_MAX) o_word_count <= o_word_count + WC_W'(1);
            end
            if (cs_rise) begin
                state        <= ST_IDLE;
                bit_cnt      <= '0;
                o_frame_done <= (state != ST_IDLE) && ((o_word_count != '0) || wen);
            end else begin
                case (state)
                    ST_IDLE: begin
                        if (cs_fall) begin
                            state        <= ST_ADDR;
                            bit_cnt      <= '0;
                            shift        <= '0;
                            o_word_count <= '0;
                        end
                    end
                    ST_ADDR, ST_DATA: begin
                        if (sck_rise) begin
                            shift <= word_next;
                            if (last_bit) begin
                                bit_cnt <= '0;
                                if (state == ST_ADDR) begin
                                    addr  <= word_next[ADDR_W-1:0];
                                    state <= ST_DATA;
                                end else begin
                                    wen   <= 1'b1;
                                    wdata <= word_next;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + BC_W'(1);
                            end
                        end
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

    assign o_busy               = (state != ST_IDLE);
    assign ram_w.o_ram_w_addr   = addr;
    assign ram_w.o_ram_w_data   = wdata;
    assign ram_w.o_ram_w_enable = wen;
endmodule

// File: tb/tb_spi_frame_loader.sv
// Directed bench for spi_frame_loader: a 12-bit instance plus a 4-bit instance
// on the same SPI pins, used to reach word-count saturation quickly.
module tb_spi_frame_loader;
    logic clk_48mhz = 1'b0;
    logic reset = 1'b1;
    logic sck = 1'b0, cs_n = 1'b1, mosi = 1'b0;

    always #10 clk_48mhz = ~clk_48mhz;

    spi_frame_loader_if #(.ADDR_W(12), .DATA_W(16)) bus ();
    spi_frame_loader_if #(.ADDR_W(4), .DATA_W(16)) bus_s ();

    logic        frame_done, busy;
    logic [12:0] wc;
    logic        done_s, busy_s;
    logic [4:0]  wc_s;

    spi_frame_loader #(.ADDR_W(12), .DATA_W(16), .SYNC_STAGES(2)) dut (
        .clk_48mhz (clk_48mhz), .reset (reset),
        .i_spi_sck (sck), .i_spi_cs_n (cs_n), .i_spi_mosi (mosi),
        .ram_w (bus), .o_frame_done (frame_done), .o_busy (busy), .o_word_count (wc)
    );

    spi_frame_loader #(.ADDR_W(4), .DATA_W(16), .SYNC_STAGES(3)) dut_s (
        .clk_48mhz (clk_48mhz), .reset (reset),
        .i_spi_sck (sck), .i_spi_cs_n (cs_n), .i_spi_mosi (mosi),
        .ram_w (bus_s), .o_frame_done (done_s), .o_busy (busy_s), .o_word_count (wc_s)
    );

    int unsigned n_vec = 0, n_bad = 0;
    logic [11:0] wr_addr[$];
    logic [15:0] wr_data[$];
    logic [3:0]  wr_addr_s[$];
    logic [15:0] wr_data_s[$];
    int unsigned done_n = 0, done_s_n = 0;

    always @(negedge clk_48mhz) begin
        if (!reset) begin
            if (bus.o_ram_w_enable) begin
                wr_addr.push_back(bus.o_ram_w_addr);
                wr_data.push_back(bus.o_ram_w_data);
            end
            if (bus_s.o_ram_w_enable) begin
                wr_addr_s.push_back(bus_s.o_ram_w_addr);
                wr_data_s.push_back(bus_s.o_ram_w_data);
            end
            if (frame_done) done_n++;
            if (done_s) done_s_n++;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // cs_mode: 0 normal, 1 CS rises with the last SCK rise, 2 CS rises one clock later
    task automatic send_bits(input logic [15:0] w, input int nbits, input int cs_mode);
        for (int i = 0; i < nbits; i++) begin
            mosi = w[15-i];
            repeat (4) @(negedge clk_48mhz);
            if (i == nbits-1 && cs_mode == 1) begin
                sck = 1'b1; cs_n = 1'b1;
            end else if (i == nbits-1 && cs_mode == 2) begin
                sck = 1'b1;
                @(negedge clk_48mhz);
                cs_n = 1'b1;
            end else begin
                sck = 1'b1;
            end
            repeat (4) @(negedge clk_48mhz);
            sck = 1'b0;
        end
    endtask

    task automatic cs_begin();
        cs_n = 1'b0;
        repeat (8) @(negedge clk_48mhz);
    endtask

    task automatic cs_end();
        repeat (8) @(negedge clk_48mhz);
        cs_n = 1'b1;
        repeat (12) @(negedge clk_48mhz);
    endtask

    int unsigned wb, db, sb, dsb;

    initial begin
        repeat (4) @(negedge clk_48mhz);
        check("rst_addr", 32'(bus.o_ram_w_addr), 0);
        check("rst_data", 32'(bus.o_ram_w_data), 0);
        check("rst_en", 32'(bus.o_ram_w_enable), 0);
        check("rst_done", 32'(frame_done), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_wc", 32'(wc), 0);
        reset = 1'b0;
        repeat (10) @(negedge clk_48mhz);

        // Basic two-word frame
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        check("t1_busy_hi", 32'(busy), 1);
        send_bits(16'h0010, 16, 0);
        send_bits(16'hA400, 16, 0);
        send_bits(16'h2400, 16, 0);
        cs_end();
        check("t1_nwr", wr_addr.size() - wb, 2);
        check("t1_a0", 32'(wr_addr[wb]), 32'h010);
        check("t1_d0", 32'(wr_data[wb]), 32'hA400);
        check("t1_a1", 32'(wr_addr[wb+1]), 32'h011);
        check("t1_d1", 32'(wr_data[wb+1]), 32'h2400);
        check("t1_done", done_n - db, 1);
        check("t1_wc", 32'(wc), 2);
        check("t1_busy_lo", 32'(busy), 0);
        check("t1_addr_hold", 32'(bus.o_ram_w_addr), 32'h012);
        check("t1_data_hold", 32'(bus.o_ram_w_data), 32'h2400);
        check("t1_en_lo", 32'(bus.o_ram_w_enable), 0);

        // Address wrap 0xFFF -> 0x000
        wb = wr_addr.size();
        cs_begin();
        send_bits(16'h0FFF, 16, 0);
        send_bits(16'h1111, 16, 0);
        send_bits(16'h2222, 16, 0);
        cs_end();
        check("t2_nwr", wr_addr.size() - wb, 2);
        check("t2_a0", 32'(wr_addr[wb]), 32'hFFF);
        check("t2_d0", 32'(wr_data[wb]), 32'h1111);
        check("t2_a1", 32'(wr_addr[wb+1]), 32'h000);
        check("t2_d1", 32'(wr_data[wb+1]), 32'h2222);
        check("t2_wc", 32'(wc), 2);

        // Partial trailing word dropped
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        send_bits(16'h0020, 16, 0);
        send_bits(16'h5555, 16, 0);
        send_bits(16'h1234, 7, 0);
        cs_end();
        check("t3_nwr", wr_addr.size() - wb, 1);
        check("t3_a0", 32'(wr_addr[wb]), 32'h020);
        check("t3_d0", 32'(wr_data[wb]), 32'h5555);
        check("t3_done", done_n - db, 1);
        check("t3_wc", 32'(wc), 1);

        // Address word only: no write, no done
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        check("t4_busy_hi", 32'(busy), 1);
        send_bits(16'hF0AB, 16, 0);
        cs_end();
        check("t4_nwr", wr_addr.size() - wb, 0);
        check("t4_done", done_n - db, 0);
        check("t4_busy_lo", 32'(busy), 0);
        check("t4_wc", 32'(wc), 0);
        check("t4_addr", 32'(bus.o_ram_w_addr), 32'h0AB);

        // Reset in the middle of a data word
        cs_begin();
        send_bits(16'h0100, 16, 0);
        send_bits(16'hFFFF, 9, 0);
        reset = 1'b1;
        @(negedge clk_48mhz);
        cs_n = 1'b1;
        repeat (3) @(negedge clk_48mhz);
        check("t5_rst_addr", 32'(bus.o_ram_w_addr), 0);
        check("t5_rst_data", 32'(bus.o_ram_w_data), 0);
        check("t5_rst_en", 32'(bus.o_ram_w_enable), 0);
        check("t5_rst_done", 32'(frame_done), 0);
        check("t5_rst_busy", 32'(busy), 0);
        check("t5_rst_wc", 32'(wc), 0);
        repeat (6) @(negedge clk_48mhz);
        reset = 1'b0;
        repeat (10) @(negedge clk_48mhz);
        check("t5_idle", 32'(busy), 0);
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        send_bits(16'h0005, 16, 0);
        send_bits(16'hFFFF, 16, 0);
        cs_end();
        check("t5_nwr", wr_addr.size() - wb, 1);
        check("t5_a0", 32'(wr_addr[wb]), 32'h005);
        check("t5_d0", 32'(wr_data[wb]), 32'hFFFF);
        check("t5_done", done_n - db, 1);
        check("t5_wc", 32'(wc), 1);

        // CS rises one clock after the 16th bit: write still completes
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        send_bits(16'h0030, 16, 0);
        send_bits(16'h0BAD, 16, 2);
        repeat (12) @(negedge clk_48mhz);
        check("t7_nwr", wr_addr.size() - wb, 1);
        check("t7_a0", 32'(wr_addr[wb]), 32'h030);
        check("t7_d0", 32'(wr_data[wb]), 32'h0BAD);
        check("t7_done", done_n - db, 1);
        check("t7_wc", 32'(wc), 1);
        check("t7_addr", 32'(bus.o_ram_w_addr), 32'h031);
        check("t7_busy", 32'(busy), 0);

        // CS and the 16th SCK rise together: CS wins, no write
        wb = wr_addr.size(); db = done_n;
        cs_begin();
        send_bits(16'h0040, 16, 0);
        send_bits(16'h7777, 16, 1);
        repeat (12) @(negedge clk_48mhz);
        check("t8_nwr", wr_addr.size() - wb, 0);
        check("t8_done", done_n - db, 0);
        check("t8_wc", 32'(wc), 0);
        check("t8_busy", 32'(busy), 0);

        // Word-count saturation and wrap on the 4-bit instance
        wb = wr_addr.size(); db = done_n;
        sb = wr_addr_s.size(); dsb = done_s_n;
        cs_begin();
        send_bits(16'h0000, 16, 0);
        for (int i = 0; i < 18; i++) send_bits(16'hC000 | 16'(i), 16, 0);
        cs_end();
        check("t6_nwr_s", wr_addr_s.size() - sb, 18);
        check("t6_a15_s", 32'(wr_addr_s[sb+15]), 32'hF);
        check("t6_d15_s", 32'(wr_data_s[sb+15]), 32'hC00F);
        check("t6_a16_s", 32'(wr_addr_s[sb+16]), 32'h0);
        check("t6_d16_s", 32'(wr_data_s[sb+16]), 32'hC010);
        check("t6_wc_s", 32'(wc_s), 32'h10);
        check("t6_done_s", done_s_n - dsb, 1);
        check("t6_busy_s", 32'(busy_s), 0);
        check("t6_nwr", wr_addr.size() - wb, 18);
        check("t6_a17", 32'(wr_addr[wb+17]), 32'h011);
        check("t6_wc", 32'(wc), 18);
        check("t6_done", done_n - db, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
